safe_access_controller: RTL and testbench
=========================================

// Module: safe_access_controller
// PURPOSE
//  Supervisor that sequences the 3-digit password checker FSM. Gates keypad traffic
//  into the checker, times out abandoned entries and holds the door open for a fixed
//  window. It re-arms the checker with a one-cycle reset and enforces a lockout after
//  repeated failures. Sits between the keypad decoder and the checker.
// PARAMETERS
//  TIMER_W        24  width of the shared dwell timer
//  FAIL_W          3  width of the failure counter
//  TIMEOUT_CYCLES 1000000  idle cycles after last digit before entry is abandoned
//  FLASH_CYCLES   250000   dwell in FAIL_SHOW
//  OPEN_CYCLES    5000000  dwell in OPEN
//  LOCKOUT_CYCLES 10000000 dwell in LOCKOUT
//  MAX_FAILS       3  consecutive failures that trigger LOCKOUT
//  Limits: all *_CYCLES are in 1..2^TIMER_W; MAX_FAILS is in 1..2^FAIL_W-1.
// PORTS
//  i_Clk              in   1  clock
//  i_Reset            in   1  synchronous, active-high reset
//  i_Keypad_DV        in   1  one-cycle strobe: new keypad digit valid
//  i_Keypad_Digit     in   4  keypad digit
//  i_Sm_Unlocked      in   1  checker status: correct password entered
//  i_Sm_Locked        in   1  checker status: wrong digit entered
//  o_Sm_Reset         out  1  reset to checker
//  o_Sm_Keypad_DV     out  1  gated strobe to checker
//  o_Sm_Keypad_Digit  out  4  digit to checker
//  o_Door_Open        out  1  high in OPEN
//  o_Fail_Flash       out  1  high in FAIL_SHOW
//  o_Lockout          out  1  high in LOCKOUT
//  o_Fail_Count       out  FAIL_W  consecutive-failure count
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, o_Fail_Count=0; o_Door_Open/o_Fail_Flash/o_Lockout=0.
//  o_Sm_Reset = i_Reset | (state==CLEAR), combinational; the checker resets in the same cycle.
//  o_Sm_Keypad_Digit = i_Keypad_Digit (pass-through, 0 latency).
//  o_Sm_Keypad_DV = i_Keypad_DV & state in {IDLE,ENTRY} & !i_Sm_Locked & !i_Sm_Unlocked.
//  Status outputs are Moore decodes of the state register.
//  Timer: loaded with N-1 on state entry (and on reload); decrements to 0.
//   Expiry is timer==0, so a dwell lasts exactly N cycles.
//  States / transitions. In ENTRY, priority is status > timeout > DV:
//   IDLE:      fwd DV -> ENTRY, load TIMEOUT.
//   ENTRY:     i_Sm_Unlocked -> OPEN, load OPEN, fail_count<=0.
//              i_Sm_Locked -> fail_count+1, saturating.
//                If new count>=MAX_FAILS -> LOCKOUT, load LOCKOUT; else FAIL_SHOW, load FLASH.
//              Expiry -> CLEAR; an abandoned entry is not a failure.
//              Fwd DV -> stay, reload TIMEOUT.
//   FAIL_SHOW: expiry -> CLEAR. Keys are dropped.
//   OPEN:      any i_Keypad_DV (manual relock) or expiry -> CLEAR. Keys are not forwarded.
//   LOCKOUT:   expiry -> CLEAR, fail_count<=0. Keys are dropped.
//   CLEAR:     1 cycle, o_Sm_Reset=1 -> IDLE. fail_count is held.
//   Illegal encodings -> CLEAR.
//  Boundaries:
//   DV coincident with checker status in ENTRY is dropped; status wins.
//   DV coincident with ENTRY expiry is dropped; the state goes to CLEAR.
//   i_Reset in any state returns to IDLE within 1 cycle and clears fail_count.
//   The reset reaches the checker in the same cycle.
//   A success clears fail_count. Failures are counted only via i_Sm_Locked.
// STRUCTURE
//  Include file safe_ctrl_defs.vh holds:
//   - 3-bit state encodings IDLE=0, ENTRY=1, FAIL_SHOW=2, OPEN=3, LOCKOUT=4, CLEAR=5.
//  One sub-module, dwell_timer: loadable down-counter with
//   - inputs i_Load and i_Value[TIMER_W-1:0];
//   - output o_Expired = (count==0).
//   The counter holds at 0 once expired.
//  The controller FSM and the failure counter live in this module.
// TESTING
//  Bench: controller + checker (password 8,6,0).
//  Parameters: TIMEOUT=20, FLASH=4, OPEN=8, LOCKOUT=16, MAX_FAILS=3.
//  1 Keys 8,6,0 at 5-cycle spacing -> o_Door_Open high exactly 8 cycles.
//    Then o_Sm_Reset pulses for 1 cycle; the state is IDLE with fail_count=0.
//  2 Keys 8,5 -> o_Fail_Flash 4 cycles, o_Fail_Count=1, o_Sm_Reset pulse.
//    Then keys 8,6,0 -> OPEN and count returns to 0.
//  3 Three wrong first digits (1,2,3) -> o_Lockout 16 cycles.
//    Keys during lockout give no o_Sm_Keypad_DV.
//    At exit, count=0 and the next 8,6,0 opens the door.
//  4 Key 8, then silence 20 cycles -> CLEAR pulse; fail count unchanged at 0.
//    Keys 6,0 afterwards -> i_Sm_Locked (entry restarted), count=1.
//  5 In OPEN, key 7 at cycle 3 of the window -> CLEAR next cycle and o_Door_Open drops.
//    The 7 is not forwarded.
//  6 i_Reset in the 2nd LOCKOUT cycle -> o_Sm_Reset=1 in the same cycle.
//    Next cycle: IDLE, all outputs 0, count=0.

Source files
------------

// File: rtl/safe_access_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : safe_access_controller_pkg
// Purpose : Shared types and constants for the safe access controller slice.
//           Holds the 3-bit controller state encoding and the keypad digit
//           width used by the bus interface.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package safe_access_controller_pkg;

  localparam int c_DIGIT_W = 4;

  // Encodings are fixed so that status decodes and debug taps stay stable.
  // Values 6 and 7 are illegal and recover through CLEAR.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_FAIL_SHOW = 3'd2,
    ST_OPEN      = 3'd3,
    ST_LOCKOUT   = 3'd4,
    ST_CLEAR     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/safe_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : safe_access_controller_if
// Purpose : Bundles the keypad-side inputs, the checker status inputs and the
//           gated checker-side outputs of the access controller.
// Ports   : i_Keypad_DV/i_Keypad_Digit  keypad strobe and digit
//           i_Sm_Unlocked/i_Sm_Locked   checker status
//           o_Sm_Reset                  reset to the checker
//           o_Sm_Keypad_DV/_Digit       gated strobe and digit to the checker
//           Modport slave = controller, master = surrounding system.
// Revision: 1.0 - initial release
// ============================================================================
interface safe_access_controller_if;
  import safe_access_controller_pkg::*;

  logic                 i_Keypad_DV;
  logic [c_DIGIT_W-1:0] i_Keypad_Digit;
  logic                 i_Sm_Unlocked;
  logic                 i_Sm_Locked;
  logic                 o_Sm_Reset;
  logic                 o_Sm_Keypad_DV;
  logic [c_DIGIT_W-1:0] o_Sm_Keypad_Digit;

  modport master (
    output i_Keypad_DV, i_Keypad_Digit, i_Sm_Unlocked, i_Sm_Locked,
    input  o_Sm_Reset, o_Sm_Keypad_DV, o_Sm_Keypad_Digit
  );

  modport slave (
    input  i_Keypad_DV, i_Keypad_Digit, i_Sm_Unlocked, i_Sm_Locked,
    output o_Sm_Reset, o_Sm_Keypad_DV, o_Sm_Keypad_Digit
  );

endinterface
`default_nettype wire

// File: rtl/safe_access_controller_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module  : dwell_timer
// Purpose : Loadable down-counter shared by all timed controller states.
//           Loading N-1 gives a dwell of exactly N cycles; the count holds at
//           zero once expired.
// Ports   : i_Clk, i_Reset (sync, active-high)
//           i_Load, i_Value[TIMER_W-1:0]  load strobe and value
//           o_Expired                     count == 0
// Revision: 1.0 - initial release
// ============================================================================
module dwell_timer #(
  parameter int TIMER_W = 24
) (
  input  wire logic               i_Clk,
  input  wire logic               i_Reset,
  input  wire logic               i_Load,
  input  wire logic [TIMER_W-1:0] i_Value,
  output logic                    o_Expired
);

  logic [TIMER_W-1:0] r_Count;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= i_Value;
    end else if (r_Count != '0) begin
      r_Count <= r_Count - TIMER_W'(1);
    end
  end

  assign o_Expired = (r_Count == '0);

endmodule
`default_nettype wire

// File: rtl/safe_access_controller.sv
`default_nettype none
// ============================================================================
// Module  : safe_access_controller
// Purpose : Supervisor around the 3-digit password checker. Gates keypad
//           strobes into the checker, abandons idle entries, holds the door
//           open for a fixed window, shows failures, enforces a lockout after
//           repeated failures and re-arms the checker with a 1-cycle reset.
// Ports   : i_Clk, i_Reset (sync, active-high)
//           bus           keypad/checker signals (slave modport)
//           o_Door_Open   high in OPEN
//           o_Fail_Flash  high in FAIL_SHOW
//           o_Lockout     high in LOCKOUT
//           o_Fail_Count  consecutive-failure count
// Revision: 1.0 - initial release
// ============================================================================
module safe_access_controller
  import safe_access_controller_pkg::*;
#(
  parameter int          TIMER_W        = 24,
  parameter int          FAIL_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FLASH_CYCLES   = 250000,
  parameter int unsigned OPEN_CYCLES    = 5000000,
  parameter int unsigned LOCKOUT_CYCLES = 10000000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  wire logic              i_Clk,
  input  wire logic              i_Reset,
  safe_access_controller_if.slave bus,
  output logic                   o_Door_Open,
  output logic                   o_Fail_Flash,
  output logic                   o_Lockout,
  output logic [FAIL_W-1:0]      o_Fail_Count
);

  localparam logic [TIMER_W-1:0] c_TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_FLASH_LOAD   = TIMER_W'(FLASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  c_MAX_FAILS    = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0]  c_FAIL_SAT     = '1;

  state_t             r_State;
  state_t             w_Next_State;
  logic [FAIL_W-1:0]  r_Fail_Count;
  logic [FAIL_W-1:0]  w_Fail_Next;
  logic [FAIL_W-1:0]  w_Fail_Inc;
  logic               w_Load;
  logic [TIMER_W-1:0] w_Load_Value;
  logic               w_Expired;
  logic               w_Fwd_DV;

  dwell_timer #(
    .TIMER_W (TIMER_W)
  ) u_dwell_timer (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Load    (w_Load),
    .i_Value   (w_Load_Value),
    .o_Expired (w_Expired)
  );

  // Keys only reach the checker while an entry can progress and the checker
  // has not yet reported a verdict.
  assign w_Fwd_DV = bus.i_Keypad_DV
                  & ((r_State == ST_IDLE) | (r_State == ST_ENTRY))
                  & ~bus.i_Sm_Locked & ~bus.i_Sm_Unlocked;

  assign w_Fail_Inc = (r_Fail_Count == c_FAIL_SAT) ? r_Fail_Count
                                                   : r_Fail_Count + FAIL_W'(1);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State      <= ST_IDLE;
      r_Fail_Count <= '0;
    end else begin
      r_State      <= w_Next_State;
      r_Fail_Count <= w_Fail_Next;
    end
  end

  always_comb begin
    w_Next_State = r_State;
    w_Fail_Next  = r_Fail_Count;
    w_Load       = 1'b0;
    w_Load_Value = c_TIMEOUT_LOAD;
    case (r_State)
      ST_IDLE: begin
        if (w_Fwd_DV) begin
          w_Next_State = ST_ENTRY;
          w_Load       = 1'b1;
        end
      end
      ST_ENTRY: begin
        // Checker verdict outranks the timeout, which outranks a new key.
        if (bus.i_Sm_Unlocked) begin
          w_Next_State = ST_OPEN;
          w_Load       = 1'b1;
          w_Load_Value = c_OPEN_LOAD;
          w_Fail_Next  = '0;
        end else if (bus.i_Sm_Locked) begin
          w_Fail_Next = w_Fail_Inc;
          w_Load      = 1'b1;
          if (w_Fail_Inc >= c_MAX_FAILS) begin
            w_Next_State = ST_LOCKOUT;
            w_Load_Value = c_LOCKOUT_LOAD;
          end else begin
            w_Next_State = ST_FAIL_SHOW;
            w_Load_Value = c_FLASH_LOAD;
          end
        end else if (w_Expired) begin
          w_Next_State = ST_CLEAR;
        end else if (w_Fwd_DV) begin
          w_Load = 1'b1;
        end
      end
      ST_FAIL_SHOW: begin
        if (w_Expired) w_Next_State = ST_CLEAR;
      end
      ST_OPEN: begin
        // Any key press relocks the door early.
        if (bus.i_Keypad_DV || w_Expired) w_Next_State = ST_CLEAR;
      end
      ST_LOCKOUT: begin
        if (w_Expired) begin
          w_Next_State = ST_CLEAR;
          w_Fail_Next  = '0;
        end
      end
      ST_CLEAR: begin
        w_Next_State = ST_IDLE;
      end
      default: begin
        w_Next_State = ST_CLEAR;
      end
    endcase
  end

  assign bus.o_Sm_Reset        = i_Reset | (r_State == ST_CLEAR);
  assign bus.o_Sm_Keypad_DV    = w_Fwd_DV;
  assign bus.o_Sm_Keypad_Digit = bus.i_Keypad_Digit;

  assign o_Door_Open  = (r_State == ST_OPEN);
  assign o_Fail_Flash = (r_State == ST_FAIL_SHOW);
  assign o_Lockout    = (r_State == ST_LOCKOUT);
  assign o_Fail_Count = r_Fail_Count;

endmodule
`default_nettype wire

// File: tb/tb_safe_access_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_safe_access_controller
// Purpose : Controller plus a behavioural 3-digit checker (password 8,6,0).
//           Directed scenarios followed by a randomized keypad phase, with a
//           deadline-based reference model of the supervisor.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_safe_access_controller;

  localparam int TIMER_W = 24;
  localparam int FAIL_W  = 3;
  localparam int TMO     = 20;
  localparam int FLASH   = 4;
  localparam int OPENC   = 8;
  localparam int LOCKC   = 16;
  localparam int MAXF    = 3;

  logic              clk;
  logic              i_Reset;
  logic              o_Door_Open, o_Fail_Flash, o_Lockout;
  logic [FAIL_W-1:0] o_Fail_Count;

  safe_access_controller_if bus ();

  safe_access_controller #(
    .TIMER_W(TIMER_W), .FAIL_W(FAIL_W), .TIMEOUT_CYCLES(TMO),
    .FLASH_CYCLES(FLASH), .OPEN_CYCLES(OPENC), .LOCKOUT_CYCLES(LOCKC),
    .MAX_FAILS(MAXF)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (i_Reset),
    .bus          (bus),
    .o_Door_Open  (o_Door_Open),
    .o_Fail_Flash (o_Fail_Flash),
    .o_Lockout    (o_Lockout),
    .o_Fail_Count (o_Fail_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural password checker ----------------
  logic [3:0] pw [3];
  int         ck_pos;
  logic       ck_unl, ck_lck;
  initial begin
    pw[0] = 4'd8; pw[1] = 4'd6; pw[2] = 4'd0;
    ck_pos = 0; ck_unl = 1'b0; ck_lck = 1'b0;
  end
  always @(posedge clk) begin
    if (bus.o_Sm_Reset) begin
      ck_pos <= 0; ck_unl <= 1'b0; ck_lck <= 1'b0;
    end else if (bus.o_Sm_Keypad_DV && !ck_unl && !ck_lck) begin
      if (bus.o_Sm_Keypad_Digit == pw[ck_pos]) begin
        if (ck_pos == 2) ck_unl <= 1'b1;
        else             ck_pos <= ck_pos + 1;
      end else begin
        ck_lck <= 1'b1;
      end
    end
  end
  assign bus.i_Sm_Unlocked = ck_unl;
  assign bus.i_Sm_Locked   = ck_lck;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model: modes with absolute deadlines ----------------
  typedef enum int {M_IDLE, M_ENTRY, M_SHOW, M_OPEN, M_LOCK, M_CLEAR} mode_t;
  mode_t m_mode   = M_CLEAR;
  int    m_dl     = 0;
  int    m_fails  = 0;
  bit    m_valid  = 0;
  int    cyc      = 0;

  // scenario observation counters
  int door_cnt, flash_cnt, lock_cnt, lock_fwd, clr_cnt;

  task automatic step(input logic rst, input logic dv, input logic [3:0] dig);
    bit   fwd;
    logic lk, ul;
    @(negedge clk);
    i_Reset = rst;
    bus.i_Keypad_DV    = dv;
    bus.i_Keypad_Digit = dig;
    #1;
    lk  = ck_lck;
    ul  = ck_unl;
    fwd = dv && (m_mode == M_IDLE || m_mode == M_ENTRY) && !lk && !ul;

    check("sm_reset", 32'(bus.o_Sm_Reset), 32'(rst || (m_valid && m_mode == M_CLEAR)));
    check("sm_digit", 32'(bus.o_Sm_Keypad_Digit), 32'(dig));
    if (m_valid) begin
      check("sm_dv", 32'(bus.o_Sm_Keypad_DV), 32'(fwd));
      check("status", 32'({o_Door_Open, o_Fail_Flash, o_Lockout}),
            32'({m_mode == M_OPEN, m_mode == M_SHOW, m_mode == M_LOCK}));
      check("fail_count", 32'(o_Fail_Count), 32'(m_fails));
    end

    if (o_Door_Open)  door_cnt++;
    if (o_Fail_Flash) flash_cnt++;
    if (o_Lockout)    lock_cnt++;
    if (o_Lockout && bus.o_Sm_Keypad_DV) lock_fwd++;
    if (bus.o_Sm_Reset) clr_cnt++;

    if (rst) begin
      m_mode  = M_IDLE;
      m_fails = 0;
      m_valid = 1;
    end else begin
      case (m_mode)
        M_IDLE:  if (fwd) begin m_mode = M_ENTRY; m_dl = cyc + TMO; end
        M_ENTRY: begin
          if (ul) begin
            m_mode = M_OPEN; m_dl = cyc + OPENC; m_fails = 0;
          end else if (lk) begin
            m_fails = (m_fails + 1 > (1 << FAIL_W) - 1) ? (1 << FAIL_W) - 1 : m_fails + 1;
            if (m_fails >= MAXF) begin m_mode = M_LOCK; m_dl = cyc + LOCKC; end
            else                 begin m_mode = M_SHOW; m_dl = cyc + FLASH; end
          end else if (cyc == m_dl) begin
            m_mode = M_CLEAR;
          end else if (fwd) begin
            m_dl = cyc + TMO;
          end
        end
        M_SHOW:  if (cyc == m_dl) m_mode = M_CLEAR;
        M_OPEN:  if (dv || cyc == m_dl) m_mode = M_CLEAR;
        M_LOCK:  if (cyc == m_dl) begin m_mode = M_CLEAR; m_fails = 0; end
        default: m_mode = M_IDLE;
      endcase
    end
    cyc++;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(15)));
  endtask

  task automatic clr_counters();
    door_cnt = 0; flash_cnt = 0; lock_cnt = 0; lock_fwd = 0; clr_cnt = 0;
  endtask

  initial begin
    bit seen;
    i_Reset = 1'b1;
    bus.i_Keypad_DV = 1'b0;
    bus.i_Keypad_Digit = 4'd0;
    clr_counters();

    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    idle(2);
    check("reset_count", 32'(o_Fail_Count), 32'd0);
    check("reset_door", 32'(o_Door_Open), 32'd0);

    // 1: correct code, door window length
    clr_counters();
    key(8); idle(4); key(6); idle(4); key(0); idle(15);
    check("s1_door_cycles", 32'(door_cnt), 32'(OPENC));
    check("s1_clear_pulses", 32'(clr_cnt), 32'd1);
    check("s1_count", 32'(o_Fail_Count), 32'd0);

    // 2: wrong second digit, then success clears count
    clr_counters();
    key(8); idle(2); key(5); idle(10);
    check("s2_flash_cycles", 32'(flash_cnt), 32'(FLASH));
    check("s2_count", 32'(o_Fail_Count), 32'd1);
    key(8); idle(2); key(6); idle(2); key(0); idle(15);
    check("s2_count_after_open", 32'(o_Fail_Count), 32'd0);

    // 3: three failures -> lockout, keys dropped, count cleared at exit
    clr_counters();
    key(1); idle(10); key(2); idle(10); key(3);
    idle(3); key(4); idle(2); key(5); idle(15);
    check("s3_lock_cycles", 32'(lock_cnt), 32'(LOCKC));
    check("s3_lock_fwd", 32'(lock_fwd), 32'd0);
    check("s3_count_exit", 32'(o_Fail_Count), 32'd0);
    clr_counters();
    key(8); idle(1); key(6); idle(1); key(0); idle(12);
    check("s3_reopen", 32'(door_cnt), 32'(OPENC));

    // 4: abandoned entry is not a failure; entry restarts
    clr_counters();
    key(8); idle(25);
    check("s4_clear_pulses", 32'(clr_cnt), 32'd1);
    check("s4_count", 32'(o_Fail_Count), 32'd0);
    key(6); idle(3); key(0); idle(10);
    check("s4_count_restart", 32'(o_Fail_Count), 32'd1);

    // 5: manual relock in the 3rd open cycle
    clr_counters();
    key(8); key(6); key(0); idle(3); key(7); idle(5);
    check("s5_door_cycles", 32'(door_cnt), 32'd3);
    check("s5_count", 32'(o_Fail_Count), 32'd0);

    // 6: reset during the 2nd lockout cycle
    key(1); idle(8); key(2); idle(8); key(3);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      idle(1);
      seen = o_Lockout;
    end
    check("s6_lockout_seen", 32'(seen), 32'd1);
    step(1'b1, 1'b0, 4'd0);
    idle(1);
    check("s6_after_rst", 32'({o_Door_Open, o_Fail_Flash, o_Lockout, bus.o_Sm_Reset}), 32'd0);
    check("s6_count", 32'(o_Fail_Count), 32'd0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] d;
      case ($urandom_range(3))
        0:       d = 4'd8;
        1:       d = 4'd6;
        2:       d = 4'd0;
        default: d = 4'($urandom_range(15));
      endcase
      if ($urandom_range(299) == 0)     step(1'b1, 1'b0, d);
      else if ($urandom_range(99) == 0) idle(22);
      else                              step(1'b0, ($urandom_range(2) == 0), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
